bram_data_port: RTL and testbench

- Parameterised single-port data-memory slave for the CPU data path, replacing fixed-size vendor-IP wrappers.
- Infers its own byte-writable block RAM with configurable depth, data width and read latency.
- Gives exactly one `ready` pulse per accepted request, including back-to-back requests with `req` held high.
- Flags out-of-range accesses with `err`.

---
 rtl/bram_data_port.sv | 117 +++++++++++
 tb/tb_bram_data_port.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_data_port.sv
// Single-port data-memory slave: byte-writable inferred block RAM behind a
// small IDLE/BUSY/DONE handshake, one ready pulse per accepted request.
module bram_data_port #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 16384,
    parameter int RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] byte_sel,
    output logic [DATA_W-1:0]   rd_data,
    output logic                ready,
    output logic                err,
    output logic                busy
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int HI    = OFF_W + IDX_W;
    localparam int VW    = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
    localparam logic [2:0] CNT_INIT = (RD_LATENCY > 1) ? 3'(RD_LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       cnt, cnt_nx;
    logic             err_l;
    logic             accept, rd_acc, in_range;
    logic [IDX_W-1:0] idx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] stage [RD_LATENCY];
    logic [VW-1:0]     vld_pipe;

    generate
        if (ADDR_W > HI) begin : g_range
            assign in_range = ~|addr[ADDR_W-1:HI];
        end else begin : g_full
            assign in_range = 1'b1;
        end
        if (OFF_W > 0) begin : g_low
            logic unused_low;
            assign unused_low = ^addr[OFF_W-1:0];
        end
    endgenerate

    assign idx    = addr[HI-1:OFF_W];
    assign accept = (state == IDLE) && req && !rst;
    assign rd_acc = accept && !we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            err_l <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) err_l <= !in_range;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (accept) begin
                if (we || RD_LATENCY == 1) begin
                    state_nx = DONE;
                end else begin
                    state_nx = BUSY;
                    cnt_nx   = CNT_INIT;
                end
            end
            BUSY: if (cnt == '0) state_nx = DONE;
                  else           cnt_nx   = cnt - 3'd1;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Gating with rst keeps a DONE cycle that coincides with reset silent.
    assign ready = (state == DONE) && !rst;
    assign err   = ready && err_l;
    assign busy  = (state != IDLE);

    // Writes commit at the acceptance edge so any later read sees them.
    always_ff @(posedge clk) begin
        if (accept && we && in_range) begin
            for (int i = 0; i < BE_W; i++)
                if (byte_sel[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    // stage[0] is the RAM output register; the last stage doubles as the
    // held rd_data, advancing only when a read result arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int k = 0; k < RD_LATENCY; k++) stage[k] <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            for (int k = 1; k < VW; k++) vld_pipe[k] <= vld_pipe[k-1];
            if (rd_acc) stage[0] <= in_range ? mem[idx] : '0;
            for (int k = 1; k < RD_LATENCY; k++)
                if (vld_pipe[k-1]) stage[k] <= stage[k-1];
        end
    end

    assign rd_data = stage[RD_LATENCY-1];

endmodule

// File: tb/tb_bram_data_port.sv
// Bench for bram_data_port: two instances (read latency 2 and 4) checked every
// cycle against a transaction-level model, plus literal spot checks.
module tb_bram_data_port;
    logic        clk = 1'b0;
    logic        rst [2];
    logic        req [2];
    logic        we  [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  bsel [2];
    logic [31:0] rdata [2];
    logic        rdy [2];
    logic        errs [2];
    logic        bsy [2];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_data_port #(.DATA_W(32), .ADDR_W(32), .DEPTH(16384), .RD_LATENCY(2)) u0 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wr_data(wdata[0]), .byte_sel(bsel[0]), .rd_data(rdata[0]),
        .ready(rdy[0]), .err(errs[0]), .busy(bsy[0]));

    bram_data_port #(.DATA_W(32), .ADDR_W(32), .DEPTH(16384), .RD_LATENCY(4)) u1 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wr_data(wdata[1]), .byte_sel(bsel[1]), .rd_data(rdata[1]),
        .ready(rdy[1]), .err(errs[1]), .busy(bsy[1]));

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, exp);
        end
    endtask

    // Transaction model: one request in flight, fixed completion time per kind.
    logic [31:0] mm [int];
    int          free_at [2] = '{0, 0};
    int          acc_c [2]   = '{0, 0};
    int          done_c [2]  = '{0, 0};
    bit          pv [2]      = '{0, 0};
    bit          p_rd [2]    = '{0, 0};
    bit          p_err [2]   = '{0, 0};
    bit          prev_rst [2] = '{1, 1};
    logic [31:0] p_data [2]  = '{0, 0};
    logic [31:0] exp_rd [2]  = '{0, 0};

    logic [31:0] lg_rd   [2][100];
    logic        lg_rdy  [2][100];
    logic        lg_err  [2][100];
    logic        lg_busy [2][100];

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic int t = cyc;
            automatic int key;
            automatic bit inr;
            automatic logic [31:0] w;
            automatic logic e_rdy, e_err, e_busy;
            if (pv[d] && t == done_c[d] && p_rd[d]) exp_rd[d] = p_data[d];
            e_rdy  = pv[d] && t == done_c[d] && !rst[d];
            e_err  = e_rdy && p_err[d];
            e_busy = pv[d] && t > acc_c[d] && t <= done_c[d];
            chk($sformatf("ready%0d", d), t, 32'(rdy[d]), 32'(e_rdy));
            chk($sformatf("err%0d", d), t, 32'(errs[d]), 32'(e_err));
            if (!(rst[d] && !prev_rst[d])) begin
                chk($sformatf("busy%0d", d), t, 32'(bsy[d]), 32'(e_busy));
                chk($sformatf("rd_data%0d", d), t, rdata[d], exp_rd[d]);
            end
            if (t < 100) begin
                lg_rd[d][t] = rdata[d];  lg_rdy[d][t] = rdy[d];
                lg_err[d][t] = errs[d];  lg_busy[d][t] = bsy[d];
            end
            if (pv[d] && t == done_c[d]) pv[d] = 0;
            if (rst[d]) begin
                pv[d] = 0;
                exp_rd[d] = '0;
                free_at[d] = t + 1;
            end else if (req[d] && t >= free_at[d]) begin
                inr = (addr[d][31:16] == 16'h0);
                key = d * 65536 + int'(addr[d][15:2]);
                w = mm.exists(key) ? mm[key] : 32'h0;
                if (we[d]) begin
                    if (inr) begin
                        for (int b = 0; b < 4; b++)
                            if (bsel[d][b]) w[8*b +: 8] = wdata[d][8*b +: 8];
                        mm[key] = w;
                    end
                    done_c[d] = t + 1;
                    p_rd[d] = 0;
                end else begin
                    p_data[d] = inr ? w : 32'h0;
                    done_c[d] = t + lat(d);
                    p_rd[d] = 1;
                end
                free_at[d] = done_c[d] + 1;
                acc_c[d] = t;
                p_err[d] = !inr;
                pv[d] = 1;
            end
            prev_rst[d] = rst[d];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] dat, input logic [3:0] be);
        req[d] = r; we[d] = w; addr[d] = a; wdata[d] = dat; bsel[d] = be;
    endtask

    task automatic seq0();
        rst[0] = 1'b1;
        drv(0, 1, 0, 32'h40, 32'h0, 4'h0);
        repeat (3) step();
        rst[0] = 1'b0;                                              // c3
        drv(0, 1, 1, 32'h40, 32'hDEADBEEF, 4'hF);           step(); // c4 DONE, req ignored
        drv(0, 1, 1, 32'h40, 32'h0, 4'hF);                  step(); // c5
        drv(0, 1, 0, 32'h40, 32'h0, 4'h0);                  step(); // c6
        drv(0, 0, 0, 32'h0, 32'h0, 4'h0);        repeat (3) step(); // c9
        drv(0, 1, 1, 32'h80, 32'h11223344, 4'hF);           step(); // c10
        drv(0, 0, 0, 32'h0, 32'h0, 4'h0);                   step(); // c11
        drv(0, 1, 1, 32'h80, 32'hAABBCCDD, 4'b0101);        step(); // c12
        drv(0, 0, 0, 32'h0, 32'h0, 4'h0);                   step(); // c13
        drv(0, 1, 0, 32'h80, 32'h0, 4'h0);                  step(); // c14
        drv(0, 0, 0, 32'h0, 32'h0, 4'h0);        repeat (2) step(); // c16
        for (int k = 0; k < 8; k++) begin
            drv(0, 1, 1, 32'h100 + 32'(4 * k), 32'h1000 + 32'(k), 4'hF);
            step();
        end                                                          // c24
        for (int k = 0; k < 12; k++) begin
            drv(0, 1, 0, 32'h100 + 32'(8 * (k % 4)), 32'h0, 4'h0);
            step();
        end                                                          // c36
        drv(0, 1, 1, 32'h0, 32'h5A5A5A5A, 4'hF);            step(); // c37
        drv(0, 0, 0, 32'h0, 32'h0, 4'h0);                   step(); // c38
        drv(0, 1, 1, 32'h00010000, 32'hFFFFFFFF, 4'hF);     step(); // c39
        drv(0, 0, 0, 32'h0, 32'h0, 4'h0);                   step(); // c40
        drv(0, 1, 0, 32'h0, 32'h0, 4'h0);                   step(); // c41
        drv(0, 0, 0, 32'h0, 32'h0, 4'h0);        repeat (2) step(); // c43
        drv(0, 1, 0, 32'h00010040, 32'h0, 4'h0);            step(); // c44
        drv(0, 0, 0, 32'h0, 32'h0, 4'h0);        repeat (3) step(); // c47
        drv(0, 1, 0, 32'h40, 32'h0, 4'h0);                  step(); // c48
        drv(0, 0, 0, 32'h0, 32'h0, 4'h0);        repeat (4) step();
    endtask

    task automatic seq1();
        rst[1] = 1'b1;
        drv(1, 1, 0, 32'h20, 32'h0, 4'h0);
        repeat (3) step();
        rst[1] = 1'b0;                                              // c3
        drv(1, 1, 1, 32'h20, 32'hCAFEF00D, 4'hF);           step(); // c4
        drv(1, 0, 0, 32'h0, 32'h0, 4'h0);                   step(); // c5
        drv(1, 1, 0, 32'h20, 32'h0, 4'h0);                  step(); // c6
        drv(1, 0, 0, 32'h0, 32'h0, 4'h0);                   step(); // c7
        rst[1] = 1'b1;                                      step(); // c8
        rst[1] = 1'b0;                           repeat (4) step(); // c12
        drv(1, 1, 0, 32'h20, 32'h0, 4'h0);                  step(); // c13
        drv(1, 0, 0, 32'h0, 32'h0, 4'h0);        repeat (4) step(); // c17
        drv(1, 1, 0, 32'h20, 32'h0, 4'h0);      repeat (10) step(); // c27
        drv(1, 0, 0, 32'h0, 32'h0, 4'h0);        repeat (3) step();
    endtask

    initial begin
        automatic int n;
        fork
            seq0();
            seq1();
        join
        repeat (2) step();

        chk("rst_ready",   1, 32'(lg_rdy[0][1]),  32'h0);
        chk("rst_busy",    2, 32'(lg_busy[0][2]), 32'h0);
        chk("rst_rd_data", 2, lg_rd[0][2],        32'h0);
        chk("wr_ready",    4, 32'(lg_rdy[0][4]),  32'h1);
        chk("done_no_req", 5, 32'(lg_rdy[0][5]),  32'h0);
        chk("rd_busy",     6, 32'(lg_busy[0][6]), 32'h1);
        chk("rd_ready",    7, 32'(lg_rdy[0][7]),  32'h1);
        chk("rd_value",    7, lg_rd[0][7],        32'hDEADBEEF);
        chk("rd_hold",     8, lg_rd[0][8],        32'hDEADBEEF);
        chk("byte_merge", 15, lg_rd[0][15],       32'h11BB33DD);
        n = 0;
        for (int c = 24; c < 36; c++) n += int'(lg_rdy[0][c]);
        chk("held_rd_pulses", 35, 32'(n), 32'd4);
        chk("held_rd_b",  29, lg_rd[0][29],       32'h00001006);
        chk("held_rd_d",  35, lg_rd[0][35],       32'h00001002);
        chk("oor_wr_err", 39, 32'(lg_err[0][39]), 32'h1);
        chk("oor_wr_nop", 42, lg_rd[0][42],       32'h5A5A5A5A);
        chk("oor_rd_val", 45, lg_rd[0][45],       32'h0);
        chk("oor_rd_err", 45, 32'(lg_err[0][45]), 32'h1);
        chk("no_stray_wr", 49, lg_rd[0][49],      32'hDEADBEEF);
        n = 0;
        for (int c = 5; c < 12; c++) n += int'(lg_rdy[1][c]) + int'(lg_err[1][c]);
        chk("rst_mid_rd_quiet", 11, 32'(n), 32'd0);
        chk("rst_mid_rd_data",   8, lg_rd[1][8],   32'h0);
        chk("post_rst_ready",   16, 32'(lg_rdy[1][16]), 32'h1);
        chk("post_rst_rd",      16, lg_rd[1][16],  32'hCAFEF00D);
        chk("l4_held_ready",    21, 32'(lg_rdy[1][21]), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
